lin_class_seq: RTL
==================

# lin_class_seq

Time-multiplexed controller for the three-input linear classifier. It accepts one sample of three signed 6-bit features over a valid/ready handshake. It then sequences a single shared 6x6 signed multiplier and 16-bit accumulator over the three weights and adds the bias. The result is presented with an output valid/ready handshake. Weights and bias are run-time programmable through a register-write port and reset to the classifier's fixed coefficients (5, 1, -9, bias -76).

## Interface

Clock `i_clk`; reset `i_rst_n`, synchronous, active-low.

Parameters:
- `W0_RST`, 6'sd5: reset value of weight 0
- `W1_RST`, 6'sd1: reset value of weight 1
- `W2_RST`, -6'sd9: reset value of weight 2
- `B_RST`, -16'sd76 (16'hFFB4): reset value of bias

Ports:
- `i_clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  synchronous active-low reset
- `i_cfg_we`  in  1  config write strobe
- `i_cfg_addr`  in  2  0=w0, 1=w1, 2=w2, 3=bias
- `i_cfg_data`  in  16  write data; weights use [5:0]
- `o_cfg_err`  out  1  one-cycle pulse: write dropped (block busy)
- `i_valid`  in  1  sample valid
- `o_ready`  out  1  block can accept a sample
- `i_im1`, `i_im2`, `i_im3`  in  6 each  signed two's-complement features
- `o_valid`  out  1  result valid
- `i_ready`  in  1  downstream accepts result
- `o_wgt_sum`  out  16  signed weighted sum
- `o_pos`  out  1  1 when `o_wgt_sum` >= 0
- `o_busy`  out  1  state != IDLE

## Operation

- FSM states and transitions:
  - IDLE: `o_ready`=1. On `i_valid`, the three features are captured, the accumulator is loaded with bias, and the FSM moves to MAC0.
  - MAC0 → MAC1: acc += x1·w0.
  - MAC1 → MAC2: acc += x2·w1.
  - MAC2 → DONE: acc += x3·w2. `o_wgt_sum` and `o_pos` are registered from the final sum on this edge.
  - DONE: `o_valid`=1. On `i_ready`, the FSM moves to IDLE.
- One multiplier is shared. Its operand mux is selected by state.
- Arithmetic:
  - Product is a 12-bit signed value, sign-extended to 16 bits.
  - Accumulation is modulo 2^16: wrap-around, no saturation, no overflow flag.
- `o_pos` = ~sum[15]. Zero counts as positive.
- Config writes:
  - Honored only in IDLE.
  - In MAC0–DONE, the write is dropped and `o_cfg_err` pulses the next cycle.
  - A weight write takes the sign from `i_cfg_data[5]`; bits [15:6] are ignored.
- Simultaneous config write and sample accept in IDLE: the write wins and is applied. The accepted sample uses the new value. A bias write is forwarded into the accumulator initial value.
- `o_wgt_sum`/`o_pos` hold their last result until the next MAC2 edge.
- `o_ready` is 0 outside IDLE. `i_valid` outside IDLE is ignored and no sample is captured.

## Timing

- Reset values: FSM=IDLE, `o_ready`=1, `o_valid`=0, `o_busy`=0, `o_cfg_err`=0, `o_wgt_sum`=16'h0000, `o_pos`=0, accumulator 0. Weights and bias are reset to the parameter values.
- Latency: a sample accepted at cycle k produces `o_valid`=1 in cycle k+4.
- `o_valid` stays high and the result stays stable until `i_ready`.
- Minimum period is 5 cycles per sample when `i_ready` is tied high.
- Reset mid-operation (any state) takes effect on the next edge:
  - The in-flight sample is discarded.
  - Outputs return to their reset values.
  - Programmed coefficients are lost and revert to the reset values.
- `o_ready`, `o_valid`, `o_busy` are decoded from registered state only, with no combinational input-to-output path.

## Test plan

- Reset defaults, sample (1,1,1):
  - `o_valid` rises in cycle accept+4.
  - `o_wgt_sum`=16'hFFB1 (-79), `o_pos`=0.
- Defaults, sample (31,31,-32) with `i_ready` low for 3 cycles in DONE:
  - `o_wgt_sum`=16'h018E (398), `o_pos`=1, held stable while `o_valid`=1.
  - `o_ready`=0, and an `i_valid` pulse during the stall is ignored.
- Write w0=6'b100000 (-32), bias=16'h7FFF, then sample (-32,0,0):
  - 1024+32767 wraps to `o_wgt_sum`=16'h83FF, `o_pos`=0.
- Write bias=0 in the same cycle as accepting sample (0,0,0):
  - `o_wgt_sum`=16'h0000, `o_pos`=1, which confirms forwarding and the zero-is-positive rule.
- `i_cfg_we` to w1 asserted in MAC1:
  - `o_cfg_err` pulses 1 cycle.
  - The result and a following sample (0,1,0) → 16'hFFB5 (-75) confirm w1 is unchanged.
- `i_rst_n` low for 1 cycle during MAC1 after programming w2=0:
  - Next cycle: IDLE, `o_valid`=0, `o_wgt_sum`=0.
  - Then sample (0,0,1) → 16'hFFAB (-85), confirming w2 reset to -9.

Source files
------------

// File: rtl/lin_class_seq.sv
// Three-feature linear classifier on one shared 6x6 multiplier; result valid 4 cycles after accept.
// Accepts a sample only in IDLE; the result is held in DONE until i_ready; config writes while busy are dropped.
module lin_class_seq #(
   parameter logic signed [5:0]  W0_RST = 6'sd5,
   parameter logic signed [5:0]  W1_RST = 6'sd1,
   parameter logic signed [5:0]  W2_RST = -6'sd9,
   parameter logic signed [15:0] B_RST  = -16'sd76
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_cfg_we,
   input  logic [1:0]  i_cfg_addr,
   input  logic [15:0] i_cfg_data,
   output logic        o_cfg_err,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [5:0]  i_im1,
   input  logic [5:0]  i_im2,
   input  logic [5:0]  i_im3,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_wgt_sum,
   output logic        o_pos,
   output logic        o_busy
);

   typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, DONE} state_t;

   state_t             state;
   logic signed [5:0]  x1, x2, x3;
   logic signed [5:0]  w0, w1, w2;
   logic signed [15:0] bias;
   logic signed [15:0] acc;
   logic signed [5:0]  op_x, op_w;
   logic signed [11:0] prod;
   logic [15:0]        acc_nxt;
   logic               cfg_err;
   logic [15:0]        wgt_sum;
   logic               pos;
   logic               bias_wr;

   assign bias_wr = i_cfg_we && (i_cfg_addr == 2'd3);

   // Operand pair for the shared multiplier follows the MAC step
   always_comb begin
      op_x = x1;
      op_w = w0;
      case (state)
         MAC1: begin
            op_x = x2;
            op_w = w1;
         end
         MAC2: begin
            op_x = x3;
            op_w = w2;
         end
         default: ;
      endcase
      prod    = op_x * op_w;
      acc_nxt = acc + {{4{prod[11]}}, prod};
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         x1      <= '0;
         x2      <= '0;
         x3      <= '0;
         w0      <= W0_RST;
         w1      <= W1_RST;
         w2      <= W2_RST;
         bias    <= B_RST;
         acc     <= '0;
         cfg_err <= 1'b0;
         wgt_sum <= '0;
         pos     <= 1'b0;
      end else begin
         cfg_err <= i_cfg_we && (state != IDLE);
         case (state)
            IDLE: begin
               if (i_cfg_we) begin
                  case (i_cfg_addr)
                     2'd0:    w0   <= i_cfg_data[5:0];
                     2'd1:    w1   <= i_cfg_data[5:0];
                     2'd2:    w2   <= i_cfg_data[5:0];
                     default: bias <= i_cfg_data;
                  endcase
               end
               if (i_valid) begin
                  x1    <= i_im1;
                  x2    <= i_im2;
                  x3    <= i_im3;
                  // A same-cycle bias write seeds the accumulator directly
                  acc   <= bias_wr ? i_cfg_data : bias;
                  state <= MAC0;
               end
            end
            MAC0: begin
               acc   <= acc_nxt;
               state <= MAC1;
            end
            MAC1: begin
               acc   <= acc_nxt;
               state <= MAC2;
            end
            MAC2: begin
               acc     <= acc_nxt;
               wgt_sum <= acc_nxt;
               pos     <= ~acc_nxt[15];
               state   <= DONE;
            end
            DONE: begin
               if (i_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_ready   = (state == IDLE);
   assign o_valid   = (state == DONE);
   assign o_busy    = (state != IDLE);
   assign o_cfg_err = cfg_err;
   assign o_wgt_sum = wgt_sum;
   assign o_pos     = pos;

endmodule
